mips_cpu_hilo_muldiv: RTL

//  Iterative multiply/divide unit and HI/LO register pair. Sits beside the ALU in the execute stage.

---
 rtl/mips_cpu_hilo_muldiv.sv | 100 ++++++++++
 1 files changed

// File: rtl/mips_cpu_hilo_muldiv.sv
// mips_cpu_hilo_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MFHI/MFLO/MTHI/MTLO access
module mips_cpu_hilo_muldiv #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_rs_content,
    input  logic [WIDTH-1:0] i_rt_content,
    output logic             o_busy,
    output logic             o_stall,
    output logic [WIDTH-1:0] o_read_data,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;
    localparam int CW = $clog2(WIDTH);
    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a, r_b, r_rs, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_sa, r_sb, r_div;
    logic               w_md_class, w_start, w_neg_a, w_neg_b, w_last, w_div_ge;
    logic [WIDTH:0]     w_mul_sum, w_div_sh;
    logic [WIDTH-1:0]   w_div_sub, w_quo, w_rem;
    logic [2*WIDTH-1:0] w_prod;
    assign o_busy      = r_state != S_IDLE;
    assign w_md_class  = i_funct inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
    assign o_stall     = i_valid & w_md_class & o_busy;
    assign w_start     = i_valid & ~o_busy & (i_funct[5:2] == 4'b0110);
    assign w_neg_a     = ~i_funct[0] & i_rs_content[WIDTH-1];
    assign w_neg_b     = ~i_funct[0] & i_rt_content[WIDTH-1];
    assign w_last      = r_cnt == CW'(WIDTH-1);
    assign o_read_data = i_funct == 6'h10 ? r_hi : i_funct == 6'h12 ? r_lo : '0;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    // Multiply: add into the upper half, then shift the whole accumulator right
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b[0] ? r_a : '0};
    // Divide: partial remainder in the upper half, quotient bits shift into the lower half
    assign w_div_sh  = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_div_ge  = w_div_sh >= {1'b0, r_b};
    assign w_div_sub = w_div_sh[WIDTH-1:0] - r_b;
    assign w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo     = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem     = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rs    <= '0;
            r_acc   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_div   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= i_funct[1] ? S_DIV : S_MUL;
                        r_div   <= i_funct[1];
                        r_a     <= w_neg_a ? -i_rs_content : i_rs_content;
                        r_b     <= w_neg_b ? -i_rt_content : i_rt_content;
                        r_rs    <= i_rs_content;
                        r_sa    <= w_neg_a;
                        r_sb    <= w_neg_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (i_valid && i_funct == 6'h11) begin
                        r_hi <= i_rs_content;
                    end else if (i_valid && i_funct == 6'h13) begin
                        r_lo <= i_rs_content;
                    end
                end
                S_MUL: begin
                    r_acc   <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? S_FIX : S_MUL;
                end
                S_DIV: begin
                    r_acc   <= {w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], w_div_ge};
                    r_a     <= r_a << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? S_FIX : S_DIV;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hi    <= !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_b == '0 ? r_rs : w_rem;
                    r_lo    <= !r_div ? w_prod[WIDTH-1:0] : r_b == '0 ? DIV_ZERO_LO : w_quo;
                end
            endcase
        end
    end
endmodule
